// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of one PicoRV32-native memory port.
// The grant is registered, and a per-transfer watchdog ends a transfer that the slave never acknowledges.
module mem_arbiter #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_pulse,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic        last_reg, last_next;
    logic [7:0]  wcnt_reg, wcnt_next;
    logic [7:0]  err_count_reg, err_count_next;

    logic        granted;
    logic        owner;
    logic        pick;
    logic        timeout_hit;
    logic        done;
    logic [31:0] done_rdata;
    logic [1:0]  m_ready;
    logic [31:0] m_rdata [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            wcnt_reg      <= 8'h00;
            err_count_reg <= 8'h00;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            wcnt_reg      <= wcnt_next;
            err_count_reg <= err_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        wcnt_next      = wcnt_reg;
        err_count_next = err_count_reg;
        granted        = 1'b0;
        owner          = 1'b0;
        pick           = 1'b0;
        timeout_hit    = 1'b0;
        done           = 1'b0;
        done_rdata     = 32'h0;

        case (state_reg)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the master that did not own the port last time wins.
                    pick       = (m0_valid && m1_valid) ? ~last_reg : m1_valid;
                    state_next = pick ? GNT1 : GNT0;
                    last_next  = pick;
                    wcnt_next  = 8'h00;
                end
            end
            GNT0, GNT1: begin
                granted     = 1'b1;
                owner       = (state_reg == GNT1);
                timeout_hit = !s_ready && (wcnt_reg == WCNT_LAST);
                if (s_ready) begin
                    done       = 1'b1;
                    done_rdata = s_rdata;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    done       = 1'b1;
                    done_rdata = ERR_DATA;
                    state_next = IDLE;
                    if (err_count_reg != 8'hFF) begin
                        err_count_next = err_count_reg + 8'h01;
                    end
                end else begin
                    wcnt_next = wcnt_reg + 8'h01;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request is withdrawn on the timeout cycle so the slave never sees a late completion.
    assign s_valid = granted && !timeout_hit;
    assign s_instr = granted ? (owner ? m1_instr : m0_instr) : 1'b0;
    assign s_addr  = granted ? (owner ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata = granted ? (owner ? m1_wdata : m0_wdata) : 32'h0;
    assign s_wstrb = granted ? (owner ? m1_wstrb : m0_wstrb) : 4'h0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign m_ready[gi] = done && (owner == 1'(gi));
            assign m_rdata[gi] = m_ready[gi] ? done_rdata : 32'h0;
            assign grant[gi]   = granted && (owner == 1'(gi));
        end
    endgenerate

    assign m0_ready      = m_ready[0];
    assign m1_ready      = m_ready[1];
    assign m0_rdata      = m_rdata[0];
    assign m1_rdata      = m_rdata[1];
    assign timeout_pulse = timeout_hit;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single-cycle vectors plus hand-written
// sequences for timeout, counter saturation and reset mid-transfer, with a completion scoreboard.
module tb_mem_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_pulse;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_pulse(timeout_pulse), .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic        m1;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    // Every completion pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (m0_ready || m1_ready) begin
            chk("sb_both_ready", 32'(m0_ready & m1_ready), 32'h0);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_master", 32'(m1_ready), 32'(e.m1));
                chk("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.data);
                $display("completion m%0d rdata %h", m1_ready, m1_ready ? m1_rdata : m0_rdata);
            end
        end
    end

    typedef struct packed {
        logic        rst, v0, v1, srdy;
        logic [31:0] srd;
        logic [1:0]  e_grant;
        logic        e_svalid, e_m0r, e_m1r;
        logic [31:0] e_m0d, e_m1d;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rst, logic v0, logic v1, logic srdy, logic [31:0] srd,
                                logic [1:0] eg, logic esv, logic em0r, logic em1r,
                                logic [31:0] em0d, logic [31:0] em1d);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.srdy = srdy; v.srd = srd;
        v.e_grant = eg; v.e_svalid = esv; v.e_m0r = em0r; v.e_m1r = em1r;
        v.e_m0d = em0d; v.e_m1d = em1d;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected slave-side fields follow directly from which master owns the port.
    task automatic check_s(string tag, logic [1:0] g);
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ei;
        ea = 32'h0; ed = 32'h0; es = 4'h0; ei = 1'b0;
        if (g == 2'b01) begin
            ea = 32'h0000_0100; ed = 32'h1111_2222; es = 4'h0; ei = 1'b1;
        end else if (g == 2'b10) begin
            ea = 32'h0000_2000; ed = 32'hCAFE_F00D; es = 4'b0011; ei = 1'b0;
        end
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_s_addr"}, s_addr, ea);
        chk({tag, "_s_wdata"}, s_wdata, ed);
        chk({tag, "_s_wstrb"}, 32'(s_wstrb), 32'(es));
        chk({tag, "_s_instr"}, 32'(s_instr), 32'(ei));
    endtask

    initial begin
        reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        m0_instr = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_2222; m0_wstrb = 4'h0;
        m1_instr = 1'b0; m1_addr = 32'h0000_2000; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;

        //             rst   v0    v1    srdy  srd            grant  sv    m0r   m1r   m0d            m1d
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678,  2'b01, 1'b1, 1'b1, 1'b0, 32'h12345678,  32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h55,        2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hA0,        2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hA1,        2'b10, 1'b1, 1'b0, 1'b1, 32'h0,         32'hA1);
        vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hA2,        2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hB0,        2'b01, 1'b1, 1'b1, 1'b0, 32'hB0,        32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hC1,        2'b10, 1'b1, 1'b0, 1'b1, 32'h0,         32'hC1);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'hD0,        2'b01, 1'b1, 1'b1, 1'b0, 32'hD0,        32'h0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);

        step();
        step();

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; m0_valid = vecs[i].v0; m1_valid = vecs[i].v1;
            s_ready = vecs[i].srdy; s_rdata = vecs[i].srd;
            if (vecs[i].e_m0r) sb_q.push_back('{m1: 1'b0, data: vecs[i].e_m0d});
            if (vecs[i].e_m1r) sb_q.push_back('{m1: 1'b1, data: vecs[i].e_m1d});
            @(negedge clk);
            check_s($sformatf("v%0d", i), vecs[i].e_grant);
            chk($sformatf("v%0d_s_valid", i), 32'(s_valid), 32'(vecs[i].e_svalid));
            chk($sformatf("v%0d_m0_ready", i), 32'(m0_ready), 32'(vecs[i].e_m0r));
            chk($sformatf("v%0d_m1_ready", i), 32'(m1_ready), 32'(vecs[i].e_m1r));
            chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].e_m0d);
            chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].e_m1d);
            chk($sformatf("v%0d_timeout", i), 32'(timeout_pulse), 32'h0);
            chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'h0);
            $display("vector %0d grant %b s_valid %b m0_ready %b m1_ready %b", i, grant, s_valid, m0_ready, m1_ready);
            step();
        end

        // Single timeout: request at N, termination exactly at N+TIMEOUT.
        s_ready = 1'b0;
        m0_valid = 1'b1;
        sb_q.push_back('{m1: 1'b0, data: 32'hDEADBEEF});
        @(negedge clk);
        chk("to_req_grant", 32'(grant), 32'h0);
        step();
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            chk($sformatf("to_c%0d_pulse", k), 32'(timeout_pulse), 32'(k == TIMEOUT));
            chk($sformatf("to_c%0d_s_valid", k), 32'(s_valid), 32'(k != TIMEOUT));
            chk($sformatf("to_c%0d_m0_ready", k), 32'(m0_ready), 32'(k == TIMEOUT));
            step();
        end
        m0_valid = 1'b0;
        @(negedge clk);
        chk("to_err_count", 32'(err_count), 32'h1);
        chk("to_idle_grant", 32'(grant), 32'h0);
        $display("single timeout err_count %0d", err_count);
        step();

        // Back-to-back timeouts: counter must stick at 255 instead of wrapping.
        for (int t = 0; t < 260; t++) sb_q.push_back('{m1: 1'b0, data: 32'hDEADBEEF});
        m0_valid = 1'b1;
        repeat (260 * (TIMEOUT + 1)) step();
        m0_valid = 1'b0;
        @(negedge clk);
        chk("sat_err_count", 32'(err_count), 32'hFF);
        chk("sat_sb_drained", 32'(sb_q.size()), 32'h0);
        $display("saturation err_count %0d", err_count);
        step();

        // Reset during a stalled GNT1: no completion, then m0 wins the first tie.
        m1_valid = 1'b1;
        @(negedge clk);
        chk("rst_req_grant", 32'(grant), 32'h0);
        step();
        @(negedge clk);
        chk("rst_gnt1_grant", 32'(grant), 32'h2);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_during_m1_ready", 32'(m1_ready), 32'h0);
        step();
        m0_valid = 1'b1;
        @(negedge clk);
        chk("rst_after_s_valid", 32'(s_valid), 32'h0);
        chk("rst_after_grant", 32'(grant), 32'h0);
        chk("rst_after_m1_ready", 32'(m1_ready), 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel_grant", 32'(grant), 32'h0);
        chk("rst_rel_err_count", 32'(err_count), 32'h0);
        step();
        s_ready = 1'b1; s_rdata = 32'h0000_00E0;
        sb_q.push_back('{m1: 1'b0, data: 32'h0000_00E0});
        @(negedge clk);
        check_s("tie_m0", 2'b01);
        chk("tie_m0_ready", 32'(m0_ready), 32'h1);
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        chk("tie_idle_grant", 32'(grant), 32'h0);
        step();
        s_ready = 1'b1; s_rdata = 32'h0000_00E1;
        sb_q.push_back('{m1: 1'b1, data: 32'h0000_00E1});
        @(negedge clk);
        check_s("tie_m1", 2'b10);
        step();
        m1_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        chk("end_grant", 32'(grant), 32'h0);
        chk("end_sb_drained", 32'(sb_q.size()), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
